// File: rtl/stream_cipher_pkg.sv
// Shared types and helpers for the keystream XOR engine and its prefetch FIFO.
package stream_cipher_pkg;

  // Default data / keystream word width.
  localparam int DATA_W_DEFAULT = 8;

  // Datapath control states: waiting for data, or holding a word until key arrives.
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_KEY = 1'b1
  } state_t;

  // Bits needed to represent an occupancy from 0 up to and including depth.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/keystream_fifo.sv
// Keystream prefetch FIFO. Pointers carry an extra wrap bit so that full and
// empty are told apart without a separate counter; occupancy is their difference.
module keystream_fifo
  import stream_cipher_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int KS_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_push,
  input  logic [DATA_W-1:0]               i_data,
  input  logic                            i_pop,
  input  logic                            i_flush,
  output logic [DATA_W-1:0]               o_head,
  output logic [level_width(KS_DEPTH)-1:0] o_level
);

  localparam int PTR_W = $clog2(KS_DEPTH);
  localparam int LVL_W = level_width(KS_DEPTH);

  logic [DATA_W-1:0] r_mem [KS_DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [PTR_W:0]    w_diff;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Occupancy and accept/reject decisions; a flush overrides both push and pop.
  always_comb begin
    w_diff    = r_wr_ptr - r_rd_ptr;
    w_full    = (w_diff == (PTR_W + 1)'(KS_DEPTH));
    w_empty   = (w_diff == '0);
    w_push_ok = 1'b0;
    w_pop_ok  = 1'b0;
    if (i_flush) begin
      w_push_ok = 1'b0;
      w_pop_ok  = 1'b0;
    end else begin
      w_push_ok = i_push && !w_full;
      w_pop_ok  = i_pop && !w_empty;
    end
  end

  // Pointer update; flush empties the FIFO by re-aligning both pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1'b1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1'b1);
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_level = LVL_W'(w_diff);

endmodule

// File: rtl/keystream_xor_engine.sv
// Stream-cipher datapath: XORs each data word with the next prefetched keystream
// word, with bypass, rekey flush and sticky error flags.
module keystream_xor_engine
  import stream_cipher_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int KS_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                byte_in,
  input  logic                             byte_in_pulse,
  input  logic                             bypass_en,
  input  logic                             rekey_pulse,
  output logic                             request_byte_pulse,
  input  logic [DATA_W-1:0]                hash_byte,
  input  logic                             hash_byte_pulse,
  output logic [DATA_W-1:0]                encrypted_byte,
  output logic                             encrypted_byte_pulse,
  output logic [level_width(KS_DEPTH)-1:0] key_level,
  output logic [CNT_W-1:0]                 byte_count,
  output logic                             overrun_err,
  output logic                             unexpected_key_err
);

  localparam int LVL_W  = level_width(KS_DEPTH);
  // Discard must absorb several back-to-back rekeys while old keys are still in flight.
  localparam int DISC_W = LVL_W + 4;
  localparam logic [LVL_W:0] DEPTH_V = (LVL_W + 1)'(KS_DEPTH);

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_pulse;
  logic [CNT_W-1:0]    r_count;
  logic                r_overrun;
  logic                r_unexpected;
  logic [LVL_W-1:0]    r_outstanding;
  logic [DISC_W-1:0]   r_discard;

  logic [LVL_W-1:0]    w_level;
  logic [DATA_W-1:0]   w_head;
  logic [LVL_W:0]      w_sum;
  logic                w_req;
  logic                w_key_disc;
  logic                w_key_take;
  logic                w_key_unexp;
  logic                w_push;
  logic [LVL_W-1:0]    w_out_next;
  logic [DISC_W:0]     w_disc_sum;
  logic [DISC_W-1:0]   w_disc_next;
  logic                w_key_avail;
  logic                w_pop;
  logic                w_emit;
  logic [DATA_W-1:0]   w_emit_data;
  logic                w_hold_load;
  logic                w_overrun;

  keystream_fifo #(
    .DATA_W   (DATA_W),
    .KS_DEPTH (KS_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (hash_byte),
    .i_pop   (w_pop),
    .i_flush (rekey_pulse),
    .o_head  (w_head),
    .o_level (w_level)
  );

  // Request a keystream word whenever stored plus in-flight keys leave room;
  // a rekey cycle never requests, and nothing is requested while in reset.
  always_comb begin
    w_sum = {1'b0, w_level} + {1'b0, r_outstanding};
    w_req = 1'b0;
    if (rst || rekey_pulse) begin
      w_req = 1'b0;
    end else if (w_sum < DEPTH_V) begin
      w_req = 1'b1;
    end else begin
      w_req = 1'b0;
    end
  end

  // Classify a returning key: dropped as stale, accepted, or unexpected.
  always_comb begin
    w_key_disc  = 1'b0;
    w_key_take  = 1'b0;
    w_key_unexp = 1'b0;
    if (!hash_byte_pulse) begin
      w_key_disc = 1'b0;
    end else if (r_discard != '0) begin
      w_key_disc = 1'b1;
    end else if (r_outstanding != '0) begin
      w_key_take = 1'b1;
    end else begin
      w_key_unexp = 1'b1;
    end
    // A key accepted in the rekey cycle belongs to the old key and is not stored.
    w_push = w_key_take && !rekey_pulse;
  end

  // Next outstanding / discard counts. On rekey every key still in flight
  // (old discards plus outstanding, less one returning this cycle) becomes stale.
  always_comb begin
    w_out_next  = r_outstanding;
    w_disc_sum  = '0;
    w_disc_next = r_discard;
    if (rekey_pulse) begin
      w_out_next  = '0;
      w_disc_sum  = {1'b0, r_discard} + (DISC_W + 1)'(r_outstanding)
                    - (DISC_W + 1)'(w_key_disc || w_key_take);
      if (w_disc_sum[DISC_W]) begin
        w_disc_next = '1;
      end else begin
        w_disc_next = w_disc_sum[DISC_W-1:0];
      end
    end else begin
      w_out_next = r_outstanding + LVL_W'(w_req) - LVL_W'(w_key_take);
      if (w_key_disc) begin
        w_disc_next = r_discard - DISC_W'(1'b1);
      end else begin
        w_disc_next = r_discard;
      end
    end
  end

  // Datapath FSM: encrypt, bypass or park a data word; a rekey hides the FIFO contents.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_emit       = 1'b0;
    w_emit_data  = r_out_data;
    w_hold_load  = 1'b0;
    w_overrun    = 1'b0;
    w_key_avail  = (w_level != '0) && !rekey_pulse;
    case (r_state)
      ST_IDLE: begin
        if (!byte_in_pulse) begin
          w_state_next = ST_IDLE;
        end else if (bypass_en) begin
          w_emit      = 1'b1;
          w_emit_data = byte_in;
        end else if (w_key_avail) begin
          w_pop       = 1'b1;
          w_emit      = 1'b1;
          w_emit_data = byte_in ^ w_head;
        end else begin
          w_hold_load  = 1'b1;
          w_state_next = ST_WAIT_KEY;
        end
      end
      ST_WAIT_KEY: begin
        if (byte_in_pulse) begin
          w_overrun = 1'b1;
        end else begin
          w_overrun = 1'b0;
        end
        if (w_key_avail) begin
          w_pop        = 1'b1;
          w_emit       = 1'b1;
          w_emit_data  = r_hold ^ w_head;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT_KEY;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Hold register for a word waiting on keystream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_hold_load) begin
      r_hold <= byte_in;
    end else begin
      r_hold <= r_hold;
    end
  end

  // Output word, its strobe and the emitted-word counter; data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_pulse <= 1'b0;
      r_count     <= '0;
    end else begin
      r_out_pulse <= w_emit;
      if (w_emit) begin
        r_out_data <= w_emit_data;
        r_count    <= r_count + CNT_W'(1'b1);
      end else begin
        r_out_data <= r_out_data;
        r_count    <= r_count;
      end
    end
  end

  // Keystream bookkeeping counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_discard     <= w_disc_next;
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun    <= 1'b0;
      r_unexpected <= 1'b0;
    end else begin
      r_overrun    <= r_overrun || w_overrun;
      r_unexpected <= r_unexpected || w_key_unexp;
    end
  end

  assign request_byte_pulse   = w_req;
  assign encrypted_byte       = r_out_data;
  assign encrypted_byte_pulse = r_out_pulse;
  assign key_level            = w_level;
  assign byte_count           = r_count;
  assign overrun_err          = r_overrun;
  assign unexpected_key_err   = r_unexpected;

endmodule
